// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM state encoding,
// requester sizing limits and small index helpers.
package uart_arb_pkg;

  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 26;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    HOLD    = 3'd5
  } arb_state_e;

  function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

  // Round-robin successor of idx among num requesters.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int num);
    return IDX_W'((int'(idx) + 1) % num);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester handshake plus UART transmitter strobe bundle.
// master = requesters and UART core side, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_busy;
  logic                 tx_start;
  logic [7:0]           tx_data;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set valid bit at or after ptr,
// searching upward with wrap-around.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [MAX_REQ-1:0] valid_pad;
  logic [IDX_W-1:0]   cand;

  assign valid_pad = MAX_REQ'(valid);

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    idx  = ptr;
    cand = ptr;
    any  = |valid;
    // Walk from the farthest offset down so the nearest set bit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (valid_pad[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter between
// NUM_REQ byte streams. Optional HOLD timeout enabled by UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic               clock,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_id,
  output logic               timeout_pulse
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_W)) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES out of counter range");
  end

  arb_state_e           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [7:0]           data_q;
  logic                 last_q;
  logic [NUM_REQ-1:0]   ready_q;
  logic                 start_q;

  // Zero-padded views so a 2-bit grant index can address any legal NUM_REQ.
  logic [MAX_REQ-1:0]   valid_pad;
  logic [MAX_REQ-1:0]   last_pad;
  logic [8*MAX_REQ-1:0] data_pad;

  assign valid_pad = MAX_REQ'(bus.req_valid);
  assign last_pad  = MAX_REQ'(bus.req_last);
  assign data_pad  = (8*MAX_REQ)'(bus.req_data);

  assign bus.req_ready = ready_q;
  assign bus.tx_start  = start_q;
  assign bus.tx_data   = data_q;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_hit;

  assign timeout_hit = (state == HOLD) && (hold_cnt == TIMEOUT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state == HOLD && !timeout_hit) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign timeout_pulse = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      ready_q     <= '0;
      start_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
    end else begin
      ready_q <= '0;
      start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            ready_q     <= NUM_REQ'(idx_onehot(pick_idx));
            state       <= LOAD;
          end
        end
        LOAD: begin
          data_q  <= data_pad[{grant_id, 3'b000} +: 8];
          last_q  <= last_pad[grant_id];
          start_q <= 1'b1;
          state   <= START;
        end
        START: state <= WAIT_HI;
        WAIT_HI: begin
          if (bus.tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (last_q) begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_idx(grant_id, NUM_REQ);
              state       <= IDLE;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // Only the granted stream may continue; others wait for release.
          if (valid_pad[grant_id]) begin
            ready_q <= NUM_REQ'(idx_onehot(grant_id));
            state   <= LOAD;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            timeout_pulse <= 1'b1;
            grant_valid   <= 1'b0;
            rr_ptr        <= next_idx(grant_id, NUM_REQ);
            state         <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a 10-cycle-busy UART model.
// The HOLD-stall scenario follows UART_ARB_TIMEOUT_EN when it is defined.
module tb_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int TO = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout_pulse;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.slave),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  logic       v [NR];
  logic [7:0] d [NR];
  logic       l [NR];
  logic       busy = 1'b0;

  for (genvar g = 0; g < NR; g++) begin : g_drv
    assign bus.req_valid[g]       = v[g];
    assign bus.req_data[8*g +: 8] = d[g];
    assign bus.req_last[g]        = l[g];
  end
  assign bus.tx_busy = busy;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected bytes per requester and expected grant order.
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         gq [$];

  int         cyc         = 0;
  int         busy_cnt    = 0;
  int         fall_cyc    = -1;
  int         gv_fall_cyc = -1;
  int         start_count = 0;
  int         pulse_count = 0;
  int         pulse_cyc   = -1;
  bit         check_gap   = 0;
  logic       gv_prev     = 1'b0;
  logic [7:0] last_sent   = '0;
  logic [7:0] exp_b;
  bit         have;
  logic [NR-1:0] oh;

  // Monitor first, then the UART busy model, all on the falling edge.
  always @(negedge clock) begin
    cyc++;
    if (bus.tx_start) begin
      start_count++;
      check("tx_start_while_busy", busy, 0);
      have  = 0;
      exp_b = '0;
      if (grant_id == 2'd0) begin
        have = q0.size() > 0;
        if (have) exp_b = q0.pop_front();
      end else begin
        have = q1.size() > 0;
        if (have) exp_b = q1.pop_front();
      end
      check("sb_entry_available", have, 1);
      check("tx_data", bus.tx_data, exp_b);
      if (check_gap && fall_cyc >= 0) check("byte_gap", cyc - fall_cyc, 3);
      last_sent = bus.tx_data;
    end
    if (busy && !reset) check("tx_data_stable", bus.tx_data, last_sent);
    if (bus.req_ready != '0) begin
      oh = NR'(1) << grant_id;
      check("ready_onehot_grant", bus.req_ready, oh);
      check("ready_with_grant", grant_valid, 1);
    end
    if (grant_valid && !gv_prev) begin
      check("grant_expected", gq.size() > 0, 1);
      if (gq.size() > 0) check("grant_order", grant_id, gq.pop_front());
    end
    if (!grant_valid && gv_prev) gv_fall_cyc = cyc;
    if (timeout_pulse) begin
      pulse_count++;
      pulse_cyc = cyc;
    end
    gv_prev = grant_valid;

    if (reset) busy_cnt = 0;
    else begin
      if (busy_cnt > 0) busy_cnt--;
      if (bus.tx_start) busy_cnt = 10;
    end
    if (busy && busy_cnt == 0) fall_cyc = cyc;
    busy = (busy_cnt != 0);
  end

  // Offer one byte; returns on the negedge where tx_start should be visible.
  task automatic push_byte(input int id, input logic [7:0] data, input logic last,
                           input int exp_wait = -1);
    int  c    = 0;
    bit  seen = 0;
    v[id] = 1'b1;
    d[id] = data;
    l[id] = last;
    if (id == 0) q0.push_back(data);
    else         q1.push_back(data);
    while (!seen && c < 2000) begin
      @(negedge clock);
      if (bus.req_ready[id]) seen = 1;
      else c++;
    end
    check("ready_seen", seen, 1);
    if (exp_wait >= 0) check("ready_latency", c, exp_wait);
    @(negedge clock);
    v[id] = 1'b0;
    if (seen) check("start_after_ready", bus.tx_start, 1);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (grant_valid && w < 3000) begin
      @(negedge clock);
      w++;
    end
    check("idle_reached", grant_valid, 0);
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      v[i] = 1'b0;
      d[i] = '0;
      l[i] = 1'b0;
    end
    repeat (3) @(negedge clock);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_pulse", timeout_pulse, 0);
    reset = 1'b0;

    // Single requester, three-byte packet.
    check_gap = 1;
    fall_cyc  = -1;
    begin
      int s0 = start_count;
      gq.push_back(0);
      push_byte(0, 8'h31, 1'b0, 0);
      push_byte(0, 8'h32, 1'b0);
      push_byte(0, 8'h33, 1'b1);
      wait_idle();
      check_gap = 0;
      check("t1_start_pulses", start_count - s0, 3);
      check("t1_release_after_fall", gv_fall_cyc - fall_cyc, 1);
      check("t1_rr_ptr", dut.rr_ptr, 1);
    end

    // Pointer at 1: simultaneous requests are served 1 then 0.
    gq.push_back(1);
    gq.push_back(0);
    fork
      push_byte(0, 8'h01, 1'b1);
      push_byte(1, 8'h02, 1'b1);
    join
    wait_idle();

    // From reset release: two simultaneous rounds of 2-byte packets.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      gq.push_back(0);
      gq.push_back(1);
      fork
        begin
          push_byte(0, 8'h10 + 8'(r), 1'b0);
          push_byte(0, 8'h18 + 8'(r), 1'b1);
        end
        begin
          push_byte(1, 8'h20 + 8'(r), 1'b0);
          push_byte(1, 8'h28 + 8'(r), 1'b1);
        end
      join
      wait_idle();
    end

    // Requester 1 arrives while requester 0 stalls in HOLD.
    gq.push_back(0);
    gq.push_back(1);
    fork
      begin
        push_byte(0, 8'h40, 1'b0);
        repeat (30) @(negedge clock);
        push_byte(0, 8'h41, 1'b1);
      end
      begin
        repeat (3) @(negedge clock);
        push_byte(1, 8'h50, 1'b1);
        check("r1_after_r0_done", q0.size(), 0);
      end
    join
    wait_idle();

    // Asynchronous reset while waiting for tx_busy to rise.
    gq.push_back(0);
    push_byte(0, 8'h70, 1'b1);
    wait_idle();
    gq.push_back(1);
    push_byte(1, 8'hA5, 1'b0);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_tx_start", bus.tx_start, 0);
    check("arst_grant_valid", grant_valid, 0);
    check("arst_tx_data", bus.tx_data, 0);
    check("arst_rr_ptr", dut.rr_ptr, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    gq.push_back(0);
    gq.push_back(1);
    fork
      push_byte(0, 8'h80, 1'b1);
      push_byte(1, 8'h81, 1'b1);
    join
    wait_idle();

    // Requester stalls in HOLD after a non-last byte.
    gq.push_back(0);
    push_byte(0, 8'h60, 1'b0);
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int w = 0;
      while (!timeout_pulse && w < 300) begin
        @(negedge clock);
        w++;
      end
      check("to_pulse_seen", timeout_pulse, 1);
      check("to_delay_in_range", (pulse_cyc - fall_cyc >= 20) && (pulse_cyc - fall_cyc <= 22), 1);
      check("to_grant_released", grant_valid, 0);
      @(negedge clock);
      check("to_pulse_one_cycle", timeout_pulse, 0);
      check("to_rr_ptr", dut.rr_ptr, 1);
      gq.push_back(1);
      gq.push_back(0);
      fork
        push_byte(0, 8'h90, 1'b1);
        push_byte(1, 8'h91, 1'b1);
      join
      wait_idle();
    end
`else
    repeat (1000) @(negedge clock);
    check("hold_grant_kept", grant_valid, 1);
    check("hold_grant_id", grant_id, 0);
    check("hold_no_timeout", pulse_count, 0);
    check("hold_no_ready", bus.req_ready, 0);
    push_byte(0, 8'h61, 1'b1);
    wait_idle();
`endif

    check("sb_q0_drained", q0.size(), 0);
    check("sb_q1_drained", q1.size(), 0);
    check("sb_grants_drained", gq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between up to four byte-stream requesters (e.g. RAM board-dump controller, status/debug reporter). Grants whole packets in round-robin order, moves each byte through a valid/ready handshake into the UART `tx_start`/`tx_data`/`tx_busy` interface, and releases the grant on the packet's last byte. It sits between the requester controllers and the UART TX core.

## Interface
- `NUM_REQ`, 2: number of requesters, legal 2..4.
- `TIMEOUT_CYCLES`, 50000000: HOLD idle limit, used only with the macro.
- `clock`  in  1  system clock; all flops are rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- `req_last`  in  NUM_REQ  marks the final byte of a packet; sampled with data.
- `req_ready`  out  NUM_REQ  one-hot byte-accept strobe.
- `tx_busy`  in  1  UART busy.
- `tx_start`  out  1  one-cycle send pulse to the UART.
- `tx_data`  out  8  byte to the UART.
- `grant_valid`  out  1  a packet is in progress.
- `grant_id`  out  2  index of the granted requester.
- `timeout_pulse`  out  1  one-cycle pulse when a grant is revoked by the timeout.

## Operation
- States: IDLE, LOAD, START, WAIT_HI, WAIT_LO, HOLD.
- IDLE: if any `req_valid` is set, pick the first set bit at or after `rr_ptr`, searching upward with wrap (ptr=3, valid=0b0011 picks 0). Register `grant_id`, set `grant_valid`, go to LOAD.
- LOAD: `req_ready[grant_id]`=1 for exactly this cycle. Capture `req_data`/`req_last` of the granted requester into `data_q`/`last_q`. Go to START.
- START: `tx_start`=1, `tx_data`=`data_q`. Go to WAIT_HI.
- WAIT_HI: wait for `tx_busy`=1, then go to WAIT_LO.
- WAIT_LO: wait for `tx_busy`=0.
  - If `last_q`=1: clear `grant_valid`, set `rr_ptr`=(`grant_id`+1) mod NUM_REQ, go to IDLE.
  - If `last_q`=0: go to HOLD.
- HOLD: when `req_valid[grant_id]`=1, go to LOAD. Other requesters are ignored until the grant is released.
- Requester rule: once `req_valid` is asserted, it stays high with stable data until `req_ready` is seen.
- `req_valid` of a non-granted requester never produces `req_ready`.
- A single-byte packet (`req_last`=1 on the first byte) releases the grant after that byte.
- `req_last` in HOLD is not examined; only the value captured in LOAD counts.
- Reset mid-operation: all state is dropped immediately; any in-flight byte is abandoned; outputs take their reset values.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `req_ready`=0, `grant_valid`=0, `grant_id`=0, `timeout_pulse`=0, `rr_ptr`=0, state IDLE.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Latency: `req_valid` seen in IDLE at cycle n gives `req_ready` at n+1 and `tx_start` at n+2.
- Byte-to-byte gap: `tx_busy` falling, then 1 cycle in HOLD (data valid), then LOAD, then `tx_start` 2 cycles after HOLD entry.
- `tx_data` holds stable from START through WAIT_LO.
- `tx_start` is never asserted while `tx_busy`=1.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 26-bit counter runs in HOLD and is cleared in every other state.
  - On reaching `TIMEOUT_CYCLES`: pulse `timeout_pulse`, release the grant, advance `rr_ptr` as for a last byte, go to IDLE.
- Not defined: no counter is built, `timeout_pulse` is tied to 0, and HOLD waits indefinitely.

## Structure
- Package `uart_arb_pkg`: state encoding constants, `MAX_REQ`=4, `IDX_W`=2, `CNT_W`=26.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs `valid[NUM_REQ]` and `ptr`; outputs `idx` and `any`.

## Test plan
- Single requester 0 sends 3 bytes 0x31,0x32,0x33 (last on 0x33), UART model holds busy for 10 cycles per byte → bytes appear in order on `tx_data`; exactly 3 `tx_start` pulses; `grant_valid` drops after the third `tx_busy` fall; `rr_ptr`=1.
- Requesters 0 and 1 both valid from reset release, 2-byte packets each → packet 0 completes fully before packet 1; a second simultaneous round is served 0 then 1.
- Requester 1 raises valid while requester 0 sits in HOLD → `req_ready[1]` stays 0 until requester 0's last byte finishes.
- Async `reset` pulse during WAIT_HI → `tx_start`/`grant_valid` go to 0 in the same cycle; the next request starts cleanly from IDLE with ptr 0.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, requester stalls in HOLD → `timeout_pulse` fires after 20 cycles, grant released; without the macro the block stays in HOLD for 1000 cycles.
